// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: one restoring step per cycle on operand
// magnitudes, with sign fix-up and a start/busy/done handshake.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_r;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   dvsr, rem_r, quo_r;
    logic [XLEN-1:0]   rem_nxt, quo_nxt;
    logic signed [XLEN:0] diff;
    logic              is_signed, dvd_neg, dvs_neg, div0, ovf, accept;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        is_signed = ~op[0];
        dvd_neg   = is_signed & rs1[XLEN-1];
        dvs_neg   = is_signed & rs2[XLEN-1];
        div0      = (rs2 == '0);
        ovf       = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
        accept    = (state == IDLE) && start && !flush;
    end

    // Restoring step: shift {rem, quo} left, trial-subtract the divisor on XLEN+1 bits
    always_comb begin
        diff    = $signed({rem_r, quo_r[XLEN-1]}) - $signed({1'b0, dvsr});
        rem_nxt = diff[XLEN] ? {rem_r[XLEN-2:0], quo_r[XLEN-1]} : diff[XLEN-1:0];
        quo_nxt = {quo_r[XLEN-2:0], ~diff[XLEN]};
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = (div0 || ovf) ? FIX : CALC;
                CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == FIX) && !flush;
        end
    end

    // Special cases preload the final quotient/remainder so FIX needs no correction
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvsr   <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_r <= op;
                dvsr <= magnitude(rs2, is_signed);
                cnt  <= '0;
                if (div0) begin
                    quo_r <= '1;
                    rem_r <= rs1;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else if (ovf) begin
                    quo_r <= MIN_NEG;
                    rem_r <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    quo_r <= magnitude(rs1, is_signed);
                    rem_r <= '0;
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                end
            end else if (state == CALC) begin
                rem_r <= rem_nxt;
                quo_r <= quo_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
            if ((state == FIX) && !flush) begin
                result <= op_r[1] ? cond_neg(rem_r, neg_r) : cond_neg(quo_r, neg_q);
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit, checked against a plain-arithmetic
// model of RV32M divide/remainder semantics.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .res(res), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sq = o[1] ? (sa % sb) : (sa / sb);
            return sq;
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one request at posedge+1; returns in the done cycle at posedge+1.
    task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output int bcyc);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bcyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #3;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        res = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct { logic [1:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] e; int l; } vec_t;

    task automatic test_directed();
        vec_t v[11];
        logic [31:0] r;
        int lat, bc;
        v[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         33};
        v[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          33};
        v[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        v[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        v[4]  = '{2'd2, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
        v[5]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        v[6]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        v[7]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1};
        v[8]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        v[9]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        v[10] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        for (int i = 0; i < 11; i++) begin
            do_div(v[i].o, v[i].a, v[i].b, r, lat, bc);
            checks++; if (r !== v[i].e) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, v[i].e); end
            checks++; if (lat != v[i].l) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].l); end
            checks++; if (bc != v[i].l) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, v[i].l); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_in_done got=%b exp=0", i, busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
            checks++; if (result !== v[i].e) begin failures++; $display("FAIL dir%0d_hold got=%h exp=%h", i, result, v[i].e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, e;
        logic [1:0] o;
        int lat, bc, k;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            k = $urandom_range(0, 7);
            case (k)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            e = model(o, a, b);
            do_div(o, a, b, r, lat, bc);
            checks++; if (r !== e) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, e); end
            checks++; if (lat != model_lat(o, a, b)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, model_lat(o, a, b)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_start();
        int lat;
        op = 2'd1; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat >= 5 && lat < 8) begin op = 2'd0; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || lat != 33) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
        checks++; if (result !== 32'd333) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", result, 32'd333); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat, bc;
        do_div(2'd1, 32'd50, 32'd5, r, lat, bc);
        checks++; if (r !== 32'd10) begin failures++; $display("FAIL b2b_first got=%h exp=%h", r, 32'd10); end
        do_div(2'd3, 32'd50, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd1) begin failures++; $display("FAIL b2b_second got=%h exp=%h", r, 32'd1); end
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat, bc, seen;
        do_div(2'd1, 32'd9, 32'd3, r, lat, bc);
        @(posedge clk); #1;
        op = 2'd1; rs1 = 32'd1234; rs2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        seen = 0;
        repeat (40) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        checks++; if (result !== 32'd3) begin failures++; $display("FAIL flush_result got=%h exp=%h", result, 32'd3); end
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_priority got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int lat, bc;
        op = 2'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2 res = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL areset_result got=%h exp=00000000", result); end
        #2 res = 1'b1;
        @(posedge clk); #1;
        do_div(2'd1, 32'hFFFF_FFFF, 32'd1, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL areset_after got=%h exp=ffffffff", r); end
        checks++; if (lat != 33) begin failures++; $display("FAIL areset_after_latency got=%0d exp=33", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
